// File: rtl/rs_pkg.sv
// Shared types for the reservation-station wakeup/select slice.
// Optional feature macro used by rs_wakeup_select: RS_STALL_CNT_EN.
package rs_pkg;

    localparam int TAG_W = 10;

    typedef logic [TAG_W-1:0] tag_t;

    // One station slot: a micro-op waiting on two source operands.
    typedef struct packed {
        logic valid;
        tag_t src1_tag;
        logic src1_rdy;
        tag_t src2_tag;
        logic src2_rdy;
        tag_t dst_tag;
    } rs_entry_t;

    typedef enum logic {
        SEL   = 1'b0,
        OFFER = 1'b1
    } sel_state_t;

    // An entry may be picked once it holds a micro-op whose sources are both available.
    function automatic logic entry_ready(input rs_entry_t e);
        return e.valid & e.src1_rdy & e.src2_rdy;
    endfunction

endpackage

// File: rtl/comparator10.sv
// 10-bit equality comparator used to match CDB tags against source tags.
module comparator10 (
    input  logic [9:0] a,
    input  logic [9:0] b,
    output logic       eq
);

    assign eq = (a == b);

endmodule

// File: rtl/rs_entry.sv
// One reservation-station entry: holds tags and ready bits, snoops the CDB
// through two comparator10 instances, and handles alloc/free/flush.
module rs_entry
    import rs_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic alloc_we,
    input  tag_t alloc_src1_tag,
    input  logic alloc_src1_rdy,
    input  tag_t alloc_src2_tag,
    input  logic alloc_src2_rdy,
    input  tag_t alloc_dst_tag,
    input  logic cdb_valid,
    input  tag_t cdb_tag,
    input  logic free,
    output logic valid,
    output logic ready,
    output tag_t dst_tag
);

    rs_entry_t q;
    tag_t      cmp1_a;
    tag_t      cmp2_a;
    logic      hit1;
    logic      hit2;

    // A free slot points its comparators at the incoming dispatch tags so a
    // broadcast in the allocation cycle is not lost; an occupied slot
    // compares its stored tags.
    assign cmp1_a = q.valid ? q.src1_tag : alloc_src1_tag;
    assign cmp2_a = q.valid ? q.src2_tag : alloc_src2_tag;

    comparator10 u_cmp1 (.a(cmp1_a), .b(cdb_tag), .eq(hit1));
    comparator10 u_cmp2 (.a(cmp2_a), .b(cdb_tag), .eq(hit2));

    // Entry state: flush beats free beats allocate beats wakeup.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (flush || free) begin
            q.valid    <= 1'b0;
            q.src1_rdy <= 1'b0;
            q.src2_rdy <= 1'b0;
        end else if (alloc_we) begin
            q.valid    <= 1'b1;
            q.src1_tag <= alloc_src1_tag;
            q.src2_tag <= alloc_src2_tag;
            q.dst_tag  <= alloc_dst_tag;
            q.src1_rdy <= alloc_src1_rdy | (cdb_valid & hit1);
            q.src2_rdy <= alloc_src2_rdy | (cdb_valid & hit2);
        end else if (q.valid) begin
            if (cdb_valid && hit1) q.src1_rdy <= 1'b1;
            if (cdb_valid && hit2) q.src2_rdy <= 1'b1;
        end
    end

    assign valid   = q.valid;
    assign ready   = entry_ready(q);
    assign dst_tag = q.dst_tag;

endmodule

// File: rtl/rs_wakeup_select.sv
// Reservation-station wakeup and round-robin select.
// Optional: define RS_STALL_CNT_EN to build the saturating issue
// backpressure counter; otherwise stall_cnt is tied to zero.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. The producer (alloc_valid from dispatch, issue_valid from this
// block) keeps its payload stable until that transfer; the consumer's ready
// never depends combinationally on the producer's valid. Here alloc_ready and
// issue_valid/issue_idx/issue_dst_tag are all derived from registered state.
module rs_wakeup_select
    import rs_pkg::*;
#(
    parameter  int ENTRIES = 4,
    parameter  int TAG_W   = 10,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [TAG_W-1:0] alloc_src1_tag,
    input  logic [TAG_W-1:0] alloc_src2_tag,
    input  logic             alloc_src1_rdy,
    input  logic             alloc_src2_rdy,
    input  logic [TAG_W-1:0] alloc_dst_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [IDX_W-1:0] issue_idx,
    output logic [TAG_W-1:0] issue_dst_tag,
    output logic [15:0]      stall_cnt,
    output sel_state_t       sel_state
);

    if (TAG_W != 10) begin : g_bad_tag_w
        $error("rs_wakeup_select: TAG_W must be 10 to match comparator10");
    end
    if (ENTRIES < 2 || ENTRIES > 8) begin : g_bad_entries
        $error("rs_wakeup_select: ENTRIES must be in 2..8");
    end

    logic [ENTRIES-1:0] ent_valid;
    logic [ENTRIES-1:0] ent_ready;
    logic [ENTRIES-1:0] alloc_we;
    logic [ENTRIES-1:0] ent_free;
    tag_t               ent_dst [ENTRIES];

    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [IDX_W-1:0]   rr_ptr;
    int                 pick_j;
    sel_state_t         state;
    logic               handshake;

    assign alloc_ready = |(~ent_valid);
    assign handshake   = issue_valid & issue_ready;
    assign sel_state   = state;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        assign alloc_we[g] = alloc_valid & alloc_ready & ~flush & (free_idx == IDX_W'(g));
        assign ent_free[g] = handshake & (issue_idx == IDX_W'(g));

        rs_entry u_entry (
            .clk            (clk),
            .reset          (reset),
            .flush          (flush),
            .alloc_we       (alloc_we[g]),
            .alloc_src1_tag (alloc_src1_tag),
            .alloc_src1_rdy (alloc_src1_rdy),
            .alloc_src2_tag (alloc_src2_tag),
            .alloc_src2_rdy (alloc_src2_rdy),
            .alloc_dst_tag  (alloc_dst_tag),
            .cdb_valid      (cdb_valid),
            .cdb_tag        (cdb_tag),
            .free           (ent_free[g]),
            .valid          (ent_valid[g]),
            .ready          (ent_ready[g]),
            .dst_tag        (ent_dst[g])
        );
    end

    // Allocator: lowest-index free slot, from registered valid bits only.
    always_comb begin
        free_idx = '0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            if (!ent_valid[IDX_W'(k)]) free_idx = IDX_W'(k);
        end
    end

    // Round-robin picker: first ready entry at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_j     = 0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            pick_j = int'(rr_ptr) + k;
            if (pick_j >= ENTRIES) pick_j = pick_j - ENTRIES;
            if (ent_ready[IDX_W'(pick_j)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(pick_j);
            end
        end
    end

    // Select FSM with registered issue outputs; flush drops any offer and
    // keeps the round-robin pointer where it was.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= SEL;
            issue_valid   <= 1'b0;
            issue_idx     <= '0;
            issue_dst_tag <= '0;
            rr_ptr        <= '0;
        end else if (flush) begin
            state       <= SEL;
            issue_valid <= 1'b0;
        end else begin
            case (state)
                SEL: begin
                    if (pick_found) begin
                        issue_idx     <= pick_idx;
                        issue_dst_tag <= ent_dst[pick_idx];
                        issue_valid   <= 1'b1;
                        state         <= OFFER;
                    end
                end
                OFFER: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        state       <= SEL;
                        rr_ptr      <= (issue_idx == IDX_W'(ENTRIES - 1)) ? '0
                                                                          : issue_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state       <= SEL;
                    issue_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RS_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count cycles the execution unit refuses an offered entry, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (flush) begin
            stall_q <= '0;
        end else if (issue_valid && !issue_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
